// File: rtl/key_pkg.sv
// Shared constants and event encoding for the key event front end.
package key_pkg;
   localparam int KEY_NKEYS   = 4;
   localparam int KEY_IDX_W   = 2;
   localparam int EVT_W       = 3;
   localparam int EVT_REL_BIT = 2;

   typedef logic [EVT_W-1:0] evt_t;

   function automatic evt_t make_evt(input logic rel, input logic [KEY_IDX_W-1:0] idx);
      make_evt = {rel, idx};
   endfunction
endpackage

// File: rtl/key_debounce.sv
// Per-key 2-flop synchronizer and debounce counter; toggle pulses on the
// cycle whose clock edge flips level.
module key_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic level,
   output logic toggle
);
   localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;
   logic             mismatch;

   // raw key is active-low, level is active-high
   assign mismatch = (~s2) != level;
   assign toggle   = mismatch && (cnt == CNT_TC);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         s1 <= key_raw;
         s2 <= s1;
         if (toggle) begin
            level <= ~level;
            cnt   <= '0;
         end else if (mismatch) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/key_ctrl.sv
// Debounced key event queue with valid/ready pop and sticky overflow flag.
// Build option: KEY_RELEASE_EVT_EN also queues release events (evt_code[2]=1).
module key_ctrl
   import key_pkg::*;
#(
   parameter int NKEYS      = KEY_NKEYS,
   parameter int DEB_CYCLES = 16,
   parameter int QDEPTH     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NKEYS-1:0] key_in,
   output logic [NKEYS-1:0] key_state,
   output logic             evt_valid,
   output logic [EVT_W-1:0] evt_code,
   input  logic             evt_ready,
   output logic             ovf,
   input  logic             ovf_clr
);
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH + 1);
   localparam logic [CNT_W-1:0] Q_FULL = CNT_W'(QDEPTH);

   logic [NKEYS-1:0] toggle;
   logic [NKEYS-1:0] rise;
   logic [NKEYS-1:0] pending;
   logic [NKEYS-1:0] pend_clr;
   logic             push;
   logic             pop;
   logic             wr_en;
   logic             drop;
   evt_t             push_code;
   evt_t             head;
   evt_t             mem [QDEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk    (clk),
         .rst    (rst),
         .key_raw(key_in[i]),
         .level  (key_state[i]),
         .toggle (toggle[i])
      );
   end

   assign rise = toggle & ~key_state;

`ifdef KEY_RELEASE_EVT_EN
   logic [NKEYS-1:0] fall;
   logic [NKEYS-1:0] pending_rel;
   logic [NKEYS-1:0] rel_clr;

   assign fall = toggle & key_state;

   always_ff @(posedge clk) begin
      if (rst) pending_rel <= '0;
      else     pending_rel <= (pending_rel & ~rel_clr) | fall;
   end
`endif

   // Lowest index wins; press requests override any release request.
   always_comb begin
      push      = 1'b0;
      push_code = '0;
      pend_clr  = '0;
`ifdef KEY_RELEASE_EVT_EN
      rel_clr   = '0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (pending_rel[i]) begin
            push       = 1'b1;
            push_code  = make_evt(1'b1, KEY_IDX_W'(i));
            rel_clr    = '0;
            rel_clr[i] = 1'b1;
         end
      end
      if (|pending) rel_clr = '0;
`endif
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            push        = 1'b1;
            push_code   = make_evt(1'b0, KEY_IDX_W'(i));
            pend_clr    = '0;
            pend_clr[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~pend_clr) | rise;
   end

   assign evt_valid = (count != '0);
   assign pop       = evt_valid & evt_ready;
   assign wr_en     = push & ((count != Q_FULL) | pop);
   assign drop      = push & (count == Q_FULL) & ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_code;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // a drop in the same cycle as a clear keeps the flag set
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   assign head = mem[rd_ptr];

`ifdef KEY_RELEASE_EVT_EN
   assign evt_code = head;
`else
   logic unused_rel_bit;
   assign unused_rel_bit = head[EVT_REL_BIT];
   assign evt_code       = {1'b0, head[KEY_IDX_W-1:0]};
`endif
endmodule

// File: tb/tb_key_ctrl.sv
// Directed table-driven bench for key_ctrl at DEB_CYCLES=16, QDEPTH=4.
module tb_key_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_in;
   logic [3:0] key_state;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic       evt_ready;
   logic       ovf;
   logic       ovf_clr;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef KEY_RELEASE_EVT_EN
   localparam logic REL_EN = 1'b1;
`else
   localparam logic REL_EN = 1'b0;
`endif

   key_ctrl #(.NKEYS(4), .DEB_CYCLES(16), .QDEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .key_in   (key_in),
      .key_state(key_state),
      .evt_valid(evt_valid),
      .evt_code (evt_code),
      .evt_ready(evt_ready),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [3:0] key;
      logic       rdy;
      logic       clr;
      int         n;
      logic [3:0] ks;
      logic       v;
      logic [2:0] code;
      logic       ov;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic [3:0] key, input logic rdy,
                               input logic clr, input int n, input logic [3:0] ks,
                               input logic v, input logic [2:0] code, input logic ov);
      vec_t t;
      t.nm = nm; t.key = key; t.rdy = rdy; t.clr = clr; t.n = n;
      t.ks = ks; t.v = v; t.code = code; t.ov = ov;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t t);
      key_in    = t.key;
      evt_ready = t.rdy;
      ovf_clr   = t.clr;
      repeat (t.n) tick();
      chk({t.nm, ".key_state"}, 8'(key_state), 8'(t.ks));
      chk({t.nm, ".evt_valid"}, 8'(evt_valid), 8'(t.v));
      if (t.v) chk({t.nm, ".evt_code"}, 8'(evt_code), 8'(t.code));
      chk({t.nm, ".ovf"}, 8'(ovf), 8'(t.ov));
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      // single press, bounce rejection, simultaneous presses
      vecs.push_back(mk("press_e16",  4'b1101, 0, 0, 17, 4'b0000, 0, 3'b000, 0));
      vecs.push_back(mk("press_e17",  4'b1101, 0, 0,  1, 4'b0010, 0, 3'b000, 0));
      vecs.push_back(mk("press_e18",  4'b1101, 0, 0,  1, 4'b0010, 1, 3'b001, 0));
      vecs.push_back(mk("press_pop",  4'b1101, 1, 0,  1, 4'b0010, 0, 3'b000, 0));
      vecs.push_back(mk("rel_k1",     4'b1111, 0, 0, 20, 4'b0000, REL_EN, 3'b101, 0));
      vecs.push_back(mk("rel_k1_pop", 4'b1111, 1, 0,  1, 4'b0000, 0, 3'b000, 0));
      vecs.push_back(mk("bounce_lo1", 4'b1110, 0, 0, 10, 4'b0000, 0, 3'b000, 0));
      vecs.push_back(mk("bounce_hi1", 4'b1111, 0, 0, 10, 4'b0000, 0, 3'b000, 0));
      vecs.push_back(mk("bounce_lo2", 4'b1110, 0, 0, 10, 4'b0000, 0, 3'b000, 0));
      vecs.push_back(mk("bounce_hi2", 4'b1111, 0, 0, 10, 4'b0000, 0, 3'b000, 0));
      vecs.push_back(mk("hold_k0",    4'b1110, 0, 0, 18, 4'b0001, 0, 3'b000, 0));
      vecs.push_back(mk("hold_k0_ev", 4'b1110, 0, 0,  1, 4'b0001, 1, 3'b000, 0));
      vecs.push_back(mk("hold_k0_pop",4'b1110, 1, 0,  1, 4'b0001, 0, 3'b000, 0));
      vecs.push_back(mk("rel_k0",     4'b1111, 0, 0, 20, 4'b0000, REL_EN, 3'b100, 0));
      vecs.push_back(mk("rel_k0_pop", 4'b1111, 1, 0,  1, 4'b0000, 0, 3'b000, 0));
      vecs.push_back(mk("all_e17",    4'b0000, 0, 0, 18, 4'b1111, 0, 3'b000, 0));
      vecs.push_back(mk("all_e18",    4'b0000, 0, 0,  1, 4'b1111, 1, 3'b000, 0));
      vecs.push_back(mk("all_e21",    4'b0000, 0, 0,  3, 4'b1111, 1, 3'b000, 0));
      vecs.push_back(mk("all_pop1",   4'b0000, 1, 0,  1, 4'b1111, 1, 3'b001, 0));
      vecs.push_back(mk("all_pop2",   4'b0000, 1, 0,  1, 4'b1111, 1, 3'b010, 0));
      vecs.push_back(mk("all_pop3",   4'b0000, 1, 0,  1, 4'b1111, 1, 3'b011, 0));
      vecs.push_back(mk("all_pop4",   4'b0000, 1, 0,  1, 4'b1111, 0, 3'b000, 0));
      vecs.push_back(mk("all_rel",    4'b1111, 0, 0, 25, 4'b0000, REL_EN, 3'b100, 0));
      vecs.push_back(mk("all_drain",  4'b1111, 1, 0,  4, 4'b0000, 0, 3'b000, 0));

      rst = 1'b1; key_in = 4'b1111; evt_ready = 1'b0; ovf_clr = 1'b0;
      repeat (3) tick();
      chk("reset.key_state", 8'(key_state), 8'h00);
      chk("reset.evt_valid", 8'(evt_valid), 8'h00);
      chk("reset.evt_code",  8'(evt_code),  8'h00);
      chk("reset.ovf",       8'(ovf),       8'h00);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

      // overflow: four presses fill the queue, a fifth is dropped
      apply(mk("ovf_fill",     4'b0000, 0, 0, 22, 4'b1111, 1, 3'b000, 0));
      apply(mk("ovf_relk0",    4'b0001, 0, 0, 20, 4'b1110, 1, 3'b000, REL_EN));
      apply(mk("ovf_preclr",   4'b0001, 0, 1,  1, 4'b1110, 1, 3'b000, 0));
      apply(mk("ovf_repress",  4'b0000, 0, 0, 18, 4'b1111, 1, 3'b000, 0));
      apply(mk("ovf_drop_clr", 4'b0000, 0, 1,  1, 4'b1111, 1, 3'b000, 1));
      apply(mk("ovf_sticky",   4'b0000, 0, 0,  2, 4'b1111, 1, 3'b000, 1));
      apply(mk("ovf_clr",      4'b0000, 0, 1,  1, 4'b1111, 1, 3'b000, 0));
      apply(mk("ovf_stays0",   4'b0000, 0, 0,  3, 4'b1111, 1, 3'b000, 0));
      // push and pop on the same edge while full
      apply(mk("pp_relk0",     4'b0001, 0, 0, 20, 4'b1110, 1, 3'b000, REL_EN));
      apply(mk("pp_relclr",    4'b0001, 0, 1,  1, 4'b1110, 1, 3'b000, 0));
      apply(mk("pp_press",     4'b0000, 0, 0, 18, 4'b1111, 1, 3'b000, 0));
      apply(mk("pp_edge",      4'b0000, 1, 0,  1, 4'b1111, 1, 3'b001, 0));
      apply(mk("pp_pop2",      4'b0000, 1, 0,  1, 4'b1111, 1, 3'b010, 0));
      apply(mk("pp_pop3",      4'b0000, 1, 0,  1, 4'b1111, 1, 3'b011, 0));
      apply(mk("pp_pop4",      4'b0000, 1, 0,  1, 4'b1111, 1, 3'b000, 0));
      apply(mk("pp_empty",     4'b0000, 1, 0,  1, 4'b1111, 0, 3'b000, 0));

      // reset with two events queued and key 3 held
      apply(mk("rst_idle",     4'b1111, 1, 0, 25, 4'b0000, 0, 3'b000, 0));
      apply(mk("rst_q2",       4'b0110, 0, 0, 20, 4'b1001, 1, 3'b000, 0));
      apply(mk("rst_k3only",   4'b0111, 0, 0, 20, 4'b1000, 1, 3'b000, 0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid.evt_valid", 8'(evt_valid), 8'h00);
      chk("rst_mid.key_state", 8'(key_state), 8'h00);
      chk("rst_mid.ovf",       8'(ovf),       8'h00);
      apply(mk("rst_e16",      4'b0111, 0, 0, 17, 4'b0000, 0, 3'b000, 0));
      apply(mk("rst_e17",      4'b0111, 0, 0,  1, 4'b1000, 0, 3'b000, 0));
      apply(mk("rst_e18",      4'b0111, 0, 0,  1, 4'b1000, 1, 3'b011, 0));

      // press then release key 2
      apply(mk("k2_pre_pop",   4'b0111, 1, 0,  1, 4'b1000, 0, 3'b000, 0));
      apply(mk("k2_idle",      4'b1111, 1, 0, 25, 4'b0000, 0, 3'b000, 0));
      apply(mk("k2_press",     4'b1011, 0, 0, 19, 4'b0100, 1, 3'b010, 0));
      apply(mk("k2_release",   4'b1111, 0, 0, 20, 4'b0000, 1, 3'b010, 0));
      apply(mk("k2_pop1",      4'b1111, 1, 0,  1, 4'b0000, REL_EN, 3'b110, 0));
      apply(mk("k2_pop2",      4'b1111, 1, 0,  1, 4'b0000, 0, 3'b000, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/key_ctrl.md
# key_ctrl

Debounced key-event front end for the 8-bit CPU: conditions the four raw active-low push-buttons (`key_in`, idle `4'b1111`) and delivers press events to the CPU core through a small event queue with a valid/ready handshake. It is the input-side counterpart of the `led_out` path and replaces direct sampling of `key_in` by the core. It sits between the board pins and the core's I/O read port.

## Interface
- `NKEYS`, 4: number of keys; fixed at 4 for this CPU, so the key index is 2 bits.
- `DEB_CYCLES`, 16: cycles a synchronized level must persist before it is accepted; minimum 2.
- `QDEPTH`, 4: event queue depth; must be a power of 2.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous reset, active-high.
- `key_in`, in, 4: raw keys, active-low, asynchronous to `clk`.
- `key_state`, out, 4: debounced level, active-high (1 = pressed).
- `evt_valid`, out, 1: queue non-empty.
- `evt_code`, out, 3: head event; [1:0] = key index, [2] = release flag.
- `evt_ready`, in, 1: consumer pops the head when `evt_valid & evt_ready`.
- `ovf`, out, 1: sticky; an event was dropped because the queue was full.
- `ovf_clr`, in, 1: clears `ovf`.

## Operation
- **Reset values**
  - Both synchronizer stages: `4'b1111`.
  - `key_state`: 0.
  - All debounce counters: 0.
  - `pending`: 0.
  - Queue: empty, so `evt_valid` = 0.
  - `evt_code`: 0.
  - `ovf`: 0.
- **Synchronizer:** 2-flop stage on `key_in` (`s1`, then `s2`).
- **Debounce, per key `i`**
  - Mismatch is `~s2[i] != key_state[i]`.
  - On mismatch, the counter increments.
  - When the counter equals `DEB_CYCLES-1` and mismatch still holds, `key_state[i]` toggles and the counter returns to 0.
  - Any cycle without mismatch clears the counter, so a glitch shorter than `DEB_CYCLES` cycles produces no change.
- **Edge capture:** a 0→1 toggle of `key_state[i]` sets `pending[i]` on the same edge. Release toggles are subject to Configuration.
- **Enqueue**
  - Each cycle, the lowest-index set `pending` bit is written to the queue and cleared. One enqueue per cycle.
  - Simultaneous presses are queued lowest index first, in consecutive cycles.
  - A new edge on a key whose `pending` bit is already set merges into that bit.
- **Queue:** FIFO of `QDEPTH` 3-bit entries with read/write pointers and a count.
  - Push while full, with no pop that cycle: the entry is dropped, the `pending` bit is still cleared, and `ovf` is set.
  - Push and pop while full: both happen and no drop occurs.
  - Push and pop while empty: the push happens and the pop is ignored.
  - Pointers wrap modulo `QDEPTH`.
- **Overflow flag:** `ovf_clr` and a new overflow in the same cycle leave `ovf` = 1.
- **Reset mid-operation:** `rst` discards queued and pending events and all counters. A key held through reset is seen as a new press `DEB_CYCLES+2` cycles after `rst` falls.

## Timing
- `key_in` changes and is stable before edge 0. Then:
  - `s2` is updated at edge 1.
  - `key_state` toggles at edge `DEB_CYCLES+1`.
  - The queue is written at edge `DEB_CYCLES+2`.
  - `evt_valid` is high after edge `DEB_CYCLES+2`; that is edge 18 at defaults.
- `evt_code` and `evt_valid` are registered and come directly from the queue head.
- Pop takes effect on the edge where `evt_valid & evt_ready`. The next entry is visible after that edge. Zero-bubble back-to-back pops are supported.
- `evt_ready` while `evt_valid` = 0 has no effect.

## Configuration
- Macro: `KEY_RELEASE_EVT_EN`.
- Defined:
  - A 1→0 toggle of `key_state` also raises a request, tracked in a separate `pending_rel` mask.
  - The event is enqueued with `evt_code[2]` = 1.
  - Arbitration order: press requests before release requests, then lowest index first.
- Undefined:
  - Release toggles are ignored.
  - `evt_code[2]` is tied to 0.
  - No `pending_rel` logic is present.

## Structure
- Shared package `key_pkg` holds:
  - Constants `KEY_NKEYS = 4`.
  - Key index width = 2.
  - `EVT_W = 3`.
  - `EVT_REL_BIT = 2`.
- Sub-module `key_debounce`: one instance per key, containing the synchronizer and the counter, with outputs `level` and `toggle`.
- Arbitration and the FIFO live in `key_ctrl`.

## Test plan
- **Single press:** `DEB_CYCLES=16`, drive `key_in = 4'b1101` from the idle state.
  - `key_state = 4'b0010` at edge 17.
  - `evt_valid` = 1 with `evt_code = 3'b001` after edge 18.
  - Assert `evt_ready` for one cycle: `evt_valid` returns to 0.
- **Bounce rejection:** toggle `key_in[0]` 1→0→1 with low phases of 10 cycles.
  - `key_state` never changes and `evt_valid` stays 0.
  - Then hold low for 16 or more cycles: exactly one event with code 0.
- **Simultaneous presses:** `key_in = 4'b0000` at once.
  - Four consecutive queue writes: codes 0, 1, 2, 3.
  - Pop with `evt_ready` held high: codes appear in order, one per cycle.
- **Overflow:** with `evt_ready` held low, produce 5 press events.
  - After the 5th, `ovf` = 1 and the queue holds codes of events 1–4.
  - `ovf_clr` then clears `ovf`.
  - Push and pop while full: `ovf` stays 0.
- **Reset mid-operation:** assert `rst` for 1 cycle with 2 events queued and key 3 held.
  - `evt_valid` = 0 after reset.
  - A fresh code-3 event appears 18 cycles after `rst` falls.
- **With `KEY_RELEASE_EVT_EN`:** press then release key 2.
  - Events in order: `3'b010`, then `3'b110`.
  - Without the macro, only `3'b010` appears.
